barrel_shifter_pipe: RTL and testbench

Parametrised, pipelined multifunction barrel shifter. Successor to the fixed 32-bit combinational rotate-left/right shifter. Supports rotate right, rotate left, logical shift right and arithmetic shift right at any power-of-two width. One pipeline stage per shift-amount bit, with a valid/ready handshake and global stall. Sits between operand registers and the writeback path of the datapath.

---
 rtl/barrel_shifter_pkg.sv | 11 +
 rtl/barrel_shift_stage.sv | 73 +++++++
 rtl/barrel_shifter_pipe.sv | 79 +++++++
 tb/tb_barrel_shifter_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared mode encoding for the pipelined barrel shifter.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_ROL = 2'b01,
    MODE_SRL = 2'b10,
    MODE_SRA = 2'b11
  } mode_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline level: conditionally shifts/rotates by SHIFT, registers the beat.
// Optional out_zero register under BARREL_SHIFTER_PIPE_ZERO_FLAG_EN.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int SHIFT = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  mode_t            in_mode,
  input  logic             in_sign,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
  output mode_t            out_mode,
  output logic             out_sign
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int BIT = $clog2(SHIFT);

  logic [WIDTH-1:0] shifted;

  // SRA fills from the operand's original sign, carried alongside the data.
  always_comb begin
    shifted = in_data;
    if (in_amt[BIT]) begin
      case (in_mode)
        MODE_ROR: shifted = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
        MODE_ROL: shifted = {in_data[WIDTH-SHIFT-1:0], in_data[WIDTH-1:WIDTH-SHIFT]};
        MODE_SRL: shifted = {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]};
        MODE_SRA: shifted = {{SHIFT{in_sign}}, in_data[WIDTH-1:SHIFT]};
        default:  shifted = in_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= MODE_ROR;
      out_sign  <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
      out_sign  <= in_sign;
    end
  end

`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b1;
    end else if (advance) begin
      out_zero <= (shifted == '0);
    end
  end
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined ROR/ROL/SRL/SRA barrel shifter, one stage per amount bit, global stall.
// Define BARREL_SHIFTER_PIPE_ZERO_FLAG_EN to add the registered out_zero flag.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  logic             advance;
  logic             v_s    [AMT_W+1];
  logic [WIDTH-1:0] d_s    [AMT_W+1];
  logic [AMT_W-1:0] amt_s  [AMT_W+1];
  mode_t            mode_s [AMT_W+1];
  logic             sign_s [AMT_W+1];

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  assign v_s[0]    = in_valid;
  assign d_s[0]    = in_data;
  assign amt_s[0]  = in_amt;
  assign mode_s[0] = mode_t'(in_mode);
  assign sign_s[0] = in_data[WIDTH-1];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    logic zero_k;
`endif
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .in_valid  (v_s[k]),
      .in_data   (d_s[k]),
      .in_amt    (amt_s[k]),
      .in_mode   (mode_s[k]),
      .in_sign   (sign_s[k]),
      .out_valid (v_s[k+1]),
      .out_data  (d_s[k+1]),
      .out_amt   (amt_s[k+1]),
      .out_mode  (mode_s[k+1]),
      .out_sign  (sign_s[k+1])
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
      ,
      .out_zero  (zero_k)
`endif
    );
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    if (k == AMT_W - 1) begin : g_zero
      assign out_zero = zero_k;
    end
`endif
  end

  assign out_valid = v_s[AMT_W];
  assign out_data  = d_s[AMT_W];
  assign out_mode  = mode_s[AMT_W];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH 32 and WIDTH 8 instances).
module tb_barrel_shifter_pipe;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int W8  = 8;
  localparam int AW8 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [AW-1:0] in_amt;
  logic [1:0]    in_mode, out_mode;

  logic           in_valid8, in_ready8, out_valid8, out_ready8;
  logic [W8-1:0]  in_data8, out_data8;
  logic [AW8-1:0] in_amt8;
  logic [1:0]     in_mode8, out_mode8;
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
  logic out_zero, out_zero8;
`endif

  barrel_shifter_pipe #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode)
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  barrel_shifter_pipe #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_amt(in_amt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_mode(out_mode8)
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    , .out_zero(out_zero8)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stalls = 0;
  int pops = 0;
  logic [W-1:0] drv_exp;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   mode;
    int           t_in;
    int           st_in;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level reference: each result bit picked straight from the operand.
  function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                            input int a, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = d[(i + a) % w];
        2'b01:   r[i] = d[(i - a + w) % w];
        2'b10:   r[i] = (i + a < w) ? d[i + a] : 1'b0;
        default: r[i] = (i + a < w) ? d[i + a] : d[w - 1];
      endcase
    end
    return r;
  endfunction

  // Monitor: each stall cycle delays every in-flight beat by one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got data %0h with empty scoreboard, expected no output", out_data);
        end else begin
          check("out_data", 64'(out_data), 64'(sb[0].data));
          check("out_mode", 64'(out_mode), 64'(sb[0].mode));
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
          check("out_zero", 64'(out_zero), 64'(sb[0].data == '0));
`endif
          if (out_ready) begin
            check("latency", 64'(cyc - sb[0].t_in), 64'(AW + stalls - sb[0].st_in));
            void'(sb.pop_front());
            pops++;
          end
        end
        if (!out_ready) stalls++;
      end
      if (in_valid && in_ready) sb.push_back('{drv_exp, in_mode, cyc, stalls});
    end
  end

  task automatic send(input logic [31:0] d, input int a, input logic [1:0] m, input logic [31:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a[AW-1:0];
    in_mode  = m;
    drv_exp  = e;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] d;
    int a;
    logic [1:0] m;
    d = $urandom;
    a = int'($urandom_range(0, W - 1));
    m = 2'($urandom_range(0, 3));
    send(d, a, m, ref_shift(W, d, a, m));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
    repeat (AW + 2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] d, input int a, input logic [1:0] m, input logic [7:0] e);
    int t0;
    int n;
    @(posedge clk);
    #1;
    in_valid8 = 1'b1;
    in_data8  = d;
    in_amt8   = a[AW8-1:0];
    in_mode8  = m;
    @(negedge clk);
    check("w8_in_ready", 64'(in_ready8), 64'(1));
    t0 = cyc;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid8 && n < 20);
    check("w8_latency", 64'(cyc - t0), 64'(AW8));
    check("w8_data", 64'(out_data8), 64'(e));
    check("w8_mode", 64'(out_mode8), 64'(m));
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    check("w8_zero", 64'(out_zero8), 64'(e == '0));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  bit rnd_done;
  int p0;

  initial begin
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; out_ready = 1'b1; drv_exp = '0;
    in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_mode8 = '0; out_ready8 = 1'b1;
    rnd_done = 1'b0;

    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_mode", 64'(out_mode), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef BARREL_SHIFTER_PIPE_ZERO_FLAG_EN
    check("rst_out_zero", 64'(out_zero), 64'(1));
`endif
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single beats with hand-derived results.
    send(32'h8000_0001, 1, 2'b00, 32'hC000_0000); drain();
    send(32'h8000_0001, 4, 2'b01, 32'h0000_0018); drain();
    send(32'h8000_0000, 31, 2'b10, 32'h0000_0001); drain();
    send(32'h8000_0000, 31, 2'b11, 32'hFFFF_FFFF); drain();
    for (int m = 0; m < 4; m++) begin
      send(32'hDEAD_BEEF, 0, 2'(m), 32'hDEAD_BEEF);
    end
    drain();
    send(32'h0000_0001, 1, 2'b10, 32'h0000_0000);
    send(32'h0000_0001, 1, 2'b00, 32'h8000_0000);
    drain();

    // 8-beat stream with a 3-cycle downstream stall in the middle.
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'(0));
          check("stall_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(pops - p0), 64'(8));

    // Random traffic with random backpressure and input gaps.
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send_rand();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("random_count", 64'(pops - p0), 64'(150));

    // Reset with three beats in flight, one already at the output.
    send_rand(); send_rand(); send_rand();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_data", 64'(out_data), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    send(32'h1234_5678, 8, 2'b01, 32'h3456_7812);
    drain();
    check("postrst_count", 64'(pops - p0), 64'(1));

    // WIDTH = 8 instance.
    run8(8'h81, 3, 2'b01, 8'h0C);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      int a;
      logic [1:0] m;
      logic [31:0] r;
      d = 8'($urandom);
      a = int'($urandom_range(0, W8 - 1));
      m = 2'($urandom_range(0, 3));
      r = ref_shift(W8, {24'h0, d}, a, m);
      run8(d, a, m, r[7:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
